// File: rtl/axis_stat_counter_core_if.sv
// Passive tap of one AXI4-Stream channel: handshake, byte enables and packet end.
// The stream owner drives through master; the statistics core only observes through slave.
interface axis_stat_counter_core_if #(
  parameter int DATA_WIDTH = 256
);
  localparam int KEEP_W = DATA_WIDTH / 8;

  logic              tvalid;
  logic              tready;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;

  modport master (output tvalid, output tready, output tkeep, output tlast);
  modport slave  (input  tvalid, input  tready, input  tkeep, input  tlast);
endinterface

// File: rtl/axis_stat_counter_core.sv
// Stream statistics core: counts packets, bytes and oversize packets on a tapped
// AXI4-Stream, and hands atomic (optionally read-and-clear) snapshots to a register slave.
module axis_stat_counter_core #(
  parameter int C_AXIS_DATA_WIDTH = 256,
  parameter int C_PKT_CNT_WIDTH   = 32,
  parameter int C_BYTE_CNT_WIDTH  = 48,
  parameter int C_MAX_PKT_BYTES   = 1518
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  axis_stat_counter_core_if.slave     s_axis,
  input  logic                        count_en,
  input  logic                        snap_req,
  input  logic                        clear_req,
  output logic                        snap_ack,
  output logic [C_PKT_CNT_WIDTH-1:0]  snap_pkt_cnt,
  output logic [C_BYTE_CNT_WIDTH-1:0] snap_byte_cnt,
  output logic [C_PKT_CNT_WIDTH-1:0]  snap_oversize_cnt,
  output logic [2:0]                  snap_ovf
);

  localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;
  localparam int BEAT_W = $clog2(KEEP_W + 1);
  localparam int LEN_W  = 16;
  localparam int PW     = C_PKT_CNT_WIDTH;
  localparam int BW     = C_BYTE_CNT_WIDTH;

  typedef enum logic {ST_IDLE, ST_IN_PKT} state_e;

  function automatic logic [BEAT_W-1:0] popcount(input logic [KEEP_W-1:0] v);
    logic [BEAT_W-1:0] c;
    c = '0;
    for (int i = 0; i < KEEP_W; i++) c = c + BEAT_W'(v[i]);
    return c;
  endfunction

  // Stage 1: accepted-beat capture
  logic              s1_valid_q, s1_valid_d;
  logic              s1_last_q,  s1_last_d;
  logic [BEAT_W-1:0] s1_bytes_q, s1_bytes_d;

  // Stage 2: packet FSM and live counters
  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [PW-1:0]     pkt_cnt_q, pkt_cnt_d;
  logic [BW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [PW-1:0]     ovs_cnt_q, ovs_cnt_d;
  logic [2:0]        ovf_q, ovf_d;

  // Snapshot registers
  logic              snap_ack_q, snap_ack_d;
  logic [PW-1:0]     snap_pkt_q, snap_pkt_d;
  logic [BW-1:0]     snap_byte_q, snap_byte_d;
  logic [PW-1:0]     snap_ovs_q, snap_ovs_d;
  logic [2:0]        snap_ovf_q, snap_ovf_d;

  logic              pkt_end;
  logic              is_oversize;
  logic [LEN_W-1:0]  pkt_len;
  logic [LEN_W:0]    len_sum;
  logic [LEN_W-1:0]  len_sat;
  logic [BEAT_W-1:0] byte_inc;
  logic              pkt_carry, byte_carry, ovs_carry;

  always_comb begin
    s1_valid_d = s_axis.tvalid & s_axis.tready & count_en;
    s1_last_d  = s_axis.tlast;
    s1_bytes_d = popcount(s_axis.tkeep);
  end

  // NOTE: every signal gets a default at the top of the block so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pkt_end = 1'b0;
    pkt_len = '0;
    len_sum = {1'b0, len_q} + (LEN_W + 1)'(s1_bytes_q);
    len_sat = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];

    if (s1_valid_q) begin
      unique case (state_q)
        ST_IDLE: begin
          if (s1_last_q) begin
            pkt_end = 1'b1;
            pkt_len = LEN_W'(s1_bytes_q);
          end else begin
            state_d = ST_IN_PKT;
            len_d   = LEN_W'(s1_bytes_q);
          end
        end
        ST_IN_PKT: begin
          if (s1_last_q) begin
            pkt_end = 1'b1;
            pkt_len = len_sat;
            state_d = ST_IDLE;
            len_d   = '0;
          end else begin
            len_d = len_sat;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A clear zeroes the base value only, so a contribution landing on the clear edge survives.
  always_comb begin
    is_oversize = pkt_end && (int'({16'd0, pkt_len}) > C_MAX_PKT_BYTES);
    byte_inc    = s1_valid_q ? s1_bytes_q : '0;

    {pkt_carry, pkt_cnt_d}  = {1'b0, (clear_req ? '0 : pkt_cnt_q)}  + (PW + 1)'(pkt_end);
    {byte_carry, byte_cnt_d} = {1'b0, (clear_req ? '0 : byte_cnt_q)} + (BW + 1)'(byte_inc);
    {ovs_carry, ovs_cnt_d}  = {1'b0, (clear_req ? '0 : ovs_cnt_q)}  + (PW + 1)'(is_oversize);

    ovf_d = (clear_req ? 3'b000 : ovf_q) | {ovs_carry, byte_carry, pkt_carry};
  end

  // Snapshot samples the live registers before this edge's update or clear.
  always_comb begin
    snap_ack_d  = snap_req;
    snap_pkt_d  = snap_req ? pkt_cnt_q  : snap_pkt_q;
    snap_byte_d = snap_req ? byte_cnt_q : snap_byte_q;
    snap_ovs_d  = snap_req ? ovs_cnt_q  : snap_ovs_q;
    snap_ovf_d  = snap_req ? ovf_q      : snap_ovf_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_bytes_q  <= '0;
      state_q     <= ST_IDLE;
      len_q       <= '0;
      pkt_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      ovs_cnt_q   <= '0;
      ovf_q       <= '0;
      snap_ack_q  <= 1'b0;
      snap_pkt_q  <= '0;
      snap_byte_q <= '0;
      snap_ovs_q  <= '0;
      snap_ovf_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_bytes_q  <= s1_bytes_d;
      state_q     <= state_d;
      len_q       <= len_d;
      pkt_cnt_q   <= pkt_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      ovs_cnt_q   <= ovs_cnt_d;
      ovf_q       <= ovf_d;
      snap_ack_q  <= snap_ack_d;
      snap_pkt_q  <= snap_pkt_d;
      snap_byte_q <= snap_byte_d;
      snap_ovs_q  <= snap_ovs_d;
      snap_ovf_q  <= snap_ovf_d;
    end
  end

  assign snap_ack          = snap_ack_q;
  assign snap_pkt_cnt      = snap_pkt_q;
  assign snap_byte_cnt     = snap_byte_q;
  assign snap_oversize_cnt = snap_ovs_q;
  assign snap_ovf          = snap_ovf_q;

endmodule

// File: doc/axis_stat_counter_core.md
Name: axis_stat_counter_core

Overview:
- Statistics core that sits directly upstream of the AXI4-Lite counter register slave.
- Passively taps one AXI4-Stream datapath and accumulates packet, byte and oversize-packet counts.
- Presents atomic snapshots of all counters to the register slave through a req/ack pair, with optional read-and-clear.
- Never drives the stream; tready is an input.

Parameters:
C_AXIS_DATA_WIDTH, 256, stream data width in bits; multiple of 8, 32..512
C_PKT_CNT_WIDTH, 32, width of packet and oversize counters
C_BYTE_CNT_WIDTH, 48, width of byte counter
C_MAX_PKT_BYTES, 1518, packets whose byte length exceeds this are counted as oversize

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
s_axis_tvalid  in  1  tapped stream valid
s_axis_tready  in  1  tapped stream ready
s_axis_tkeep  in  C_AXIS_DATA_WIDTH/8  byte enables of tapped beat
s_axis_tlast  in  1  end of packet
count_en  in  1  1 = accumulate, 0 = ignore beats
snap_req  in  1  single-cycle snapshot request from register slave
clear_req  in  1  single-cycle clear request (read-and-clear when coincident with snap_req)
snap_ack  out  1  one-cycle pulse: snapshot outputs updated
snap_pkt_cnt  out  C_PKT_CNT_WIDTH  snapshot packet count
snap_byte_cnt  out  C_BYTE_CNT_WIDTH  snapshot byte count
snap_oversize_cnt  out  C_PKT_CNT_WIDTH  snapshot oversize-packet count
snap_ovf  out  3  sticky wrap flags {oversize, byte, pkt} at snapshot time

Behaviour:
- Beat accepted when s_axis_tvalid & s_axis_tready & count_en at a rising ACLK edge.
- Stage 1 (registered): beat_bytes = popcount(tkeep), valid flag, last flag. Non-contiguous tkeep is legal; popcount is used.
- Stage 2 (registered): live counters update.
- Latency: a beat accepted at cycle N is reflected in the live counters after the edge ending cycle N+1. A snap_req at N+2 includes it.
- Packet-length FSM, two states:
  - IDLE: accepted beat with tlast=0 -> IN_PKT, len = beat_bytes. Accepted beat with tlast=1 -> single-beat packet, stay in IDLE.
  - IN_PKT: len += beat_bytes; on tlast return to IDLE.
  - On packet end: pkt_cnt += 1; if final len > C_MAX_PKT_BYTES, oversize_cnt += 1.
  - len register is 16 bits and saturates at 0xFFFF.
- byte_cnt += beat_bytes on every accepted beat, independent of the FSM.
- All counters wrap modulo 2^width. On wrap, the matching sticky ovf bit sets; it is cleared only by clear_req or reset.
- count_en deasserted mid-packet:
  - Beats are ignored; FSM state is held.
  - Packet completes on the next accepted tlast beat.
  - Beats already in stage 1 still complete.
- Snapshot: snap_req at cycle N latches live counters and ovf into the snap_* registers at the edge ending N. snap_ack is high during cycle N+1. snap_* are stable until the next snapshot.
- Clear: clear_req at cycle N zeroes pkt_cnt, byte_cnt, oversize_cnt and ovf at the edge ending N.
  - Any stage-2 contribution landing in that same edge is kept, so the counter becomes that contribution alone and no event is lost.
  - FSM and len are not cleared; a packet in progress is counted at its tlast.
- snap_req and clear_req in the same cycle: the snapshot captures pre-clear values, then the counters clear (read-and-clear).
- snap_req while snap_ack is high: legal; a new snapshot occurs and snap_ack is high again the following cycle.
- Reset (ARESET=1 at an edge), including mid-packet:
  - All counters, len, ovf, snap_* and snap_ack go to 0; FSM goes to IDLE; pipeline valid flags are cleared.
  - The packet in flight is not counted.
  - Beats presented during reset are ignored.

Test Plan:
- Reset values: hold ARESET 5 cycles, release, snap_req -> snap_ack next cycle, all snap_* = 0, snap_ovf = 3'b000.
- Three packets of 64, 100 and 1518 bytes (full beats plus partial last tkeep), then snap_req after idle -> pkt = 3, byte = 1682, oversize = 0. A 1519-byte packet followed by snap_req -> oversize = 1.
- Latency: single-beat packet with tkeep = all-ones accepted at N, snap_req at N+1 -> pkt = 0; snap_req at N+2 -> pkt = 1, byte = 32.
- Read-and-clear: after 5 packets, snap_req+clear_req together -> snap_pkt = 5. Next snap_req -> snap_pkt = 0, unless a beat landed in the clear edge, in which case byte count equals that beat's bytes.
- Wrap: C_PKT_CNT_WIDTH = 4, send 17 packets -> snap_pkt = 1, snap_ovf[0] = 1. After clear_req, snap_ovf = 0.
- Mid-packet events:
  - count_en low for 2 middle beats of a 4-beat 128-byte packet -> byte = 64, pkt = 1.
  - ARESET asserted mid-packet, then one 64-byte packet -> pkt = 1, byte = 64.
  - tready low with tvalid high -> no counting.
